// File: rtl/awg_pkg.sv
// Shared constants, FSM encoding and field codes for the AWG command parser.
// Commands look like "<ch><field><digits><CR|LF>", e.g. "1F1000\n".
package awg_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_F  = 8'h46;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_P  = 8'h50;
    localparam logic [7:0] ASCII_W  = 8'h57;

    localparam int ACC_W      = 17;
    localparam int MAX_DIGITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIELD,
        ST_DIGITS,
        ST_DISCARD
    } state_t;

    typedef enum logic [1:0] {
        FLD_FREQ,
        FLD_AMP,
        FLD_PHASE,
        FLD_WAVE
    } field_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    function automatic logic is_field(input logic [7:0] b);
        return (b == ASCII_F) || (b == ASCII_A) || (b == ASCII_P) || (b == ASCII_W);
    endfunction

    function automatic field_t to_field(input logic [7:0] b);
        case (b)
            ASCII_A: return FLD_AMP;
            ASCII_P: return FLD_PHASE;
            ASCII_W: return FLD_WAVE;
            default: return FLD_FREQ;
        endcase
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/awg_dec_acc.sv
// Decimal accumulator for the parser: collects digits, counts them and
// presents the value saturated to the width of the selected field.
module awg_dec_acc
    import awg_pkg::*;
#(
    parameter int FREQ_W  = 16,
    parameter int AMP_W   = 3,
    parameter int PHASE_W = 8,
    parameter int WAVE_W  = 2,
    parameter int VAL_W   = max4(FREQ_W, AMP_W, PHASE_W, WAVE_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_digitEn,
    input  logic [3:0]       i_digit,
    input  field_t           i_satSel,
    output logic [2:0]       o_count,
    output logic [VAL_W-1:0] o_satValue
);

    localparam int CW = (VAL_W > ACC_W) ? VAL_W : ACC_W;

    logic [ACC_W-1:0] r_acc;
    logic [2:0]       r_count;
    logic [CW-1:0]    w_accExt;
    logic [CW-1:0]    w_maxExt;
    int               w_width;

    // Five digits at most, so acc*10+digit never exceeds 99999 and fits 17 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_digitEn) begin
            r_acc   <= r_acc * ACC_W'(10) + ACC_W'(i_digit);
            r_count <= r_count + 3'd1;
        end
    end

    always_comb begin
        w_width = FREQ_W;
        case (i_satSel)
            FLD_AMP:   w_width = AMP_W;
            FLD_PHASE: w_width = PHASE_W;
            FLD_WAVE:  w_width = WAVE_W;
            default:   w_width = FREQ_W;
        endcase
        w_accExt   = CW'(r_acc);
        w_maxExt   = (CW'(1) << w_width) - CW'(1);
        o_satValue = (w_accExt > w_maxExt) ? w_maxExt[VAL_W-1:0] : w_accExt[VAL_W-1:0];
    end

    assign o_count = r_count;

endmodule

// File: rtl/awg_cmd_parser.sv
// ASCII command parser for a multi-channel AWG: decodes UART bytes into
// per-channel frequency, amplitude, phase and waveform registers.
module awg_cmd_parser
    import awg_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int FREQ_W   = 16,
    parameter int AMP_W    = 3,
    parameter int PHASE_W  = 8,
    parameter int WAVE_W   = 2,
    parameter int FREQ_RST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [NCH*FREQ_W-1:0]  freq_o,
    output logic [NCH*AMP_W-1:0]   amp_o,
    output logic [NCH*PHASE_W-1:0] phase_o,
    output logic [NCH*WAVE_W-1:0]  wave_o,
    output logic                 update,
    output logic [2:0]           upd_ch,
    output logic                 err
);

    localparam int         VAL_W   = max4(FREQ_W, AMP_W, PHASE_W, WAVE_W);
    localparam logic [7:0] CH_LAST = 8'(int'(ASCII_0) + NCH - 1);

    state_t r_state;
    state_t w_nextState;
    field_t r_field;
    logic [2:0] r_ch;
    logic [2:0] r_updCh;
    logic       r_update;
    logic       r_err;

    logic [FREQ_W-1:0]  r_freq  [NCH];
    logic [AMP_W-1:0]   r_amp   [NCH];
    logic [PHASE_W-1:0] r_phase [NCH];
    logic [WAVE_W-1:0]  r_wave  [NCH];

    logic w_isCh, w_isTerm, w_isDigit, w_isField;
    logic w_latchCh, w_latchField, w_accClear, w_digitEn, w_write, w_errSet;
    logic [2:0]       w_count;
    logic [VAL_W-1:0] w_satValue;

    awg_dec_acc #(
        .FREQ_W  (FREQ_W),
        .AMP_W   (AMP_W),
        .PHASE_W (PHASE_W),
        .WAVE_W  (WAVE_W),
        .VAL_W   (VAL_W)
    ) u_decAcc (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_accClear),
        .i_digitEn  (w_digitEn),
        .i_digit    (rx_data[3:0]),
        .i_satSel   (r_field),
        .o_count    (w_count),
        .o_satValue (w_satValue)
    );

    always_comb begin
        w_isCh       = (rx_data >= ASCII_0) && (rx_data <= CH_LAST);
        w_isTerm     = is_term(rx_data);
        w_isDigit    = is_digit(rx_data);
        w_isField    = is_field(rx_data);
        w_nextState  = r_state;
        w_latchCh    = 1'b0;
        w_latchField = 1'b0;
        w_accClear   = 1'b0;
        w_digitEn    = 1'b0;
        w_write      = 1'b0;
        w_errSet     = 1'b0;
        if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    // A bare terminator here is a blank line or the LF of a CR/LF pair.
                    if (w_isCh) begin
                        w_latchCh   = 1'b1;
                        w_nextState = ST_FIELD;
                    end else if (!w_isTerm) begin
                        w_nextState = ST_DISCARD;
                    end
                end
                ST_FIELD: begin
                    if (w_isField) begin
                        w_latchField = 1'b1;
                        w_accClear   = 1'b1;
                        w_nextState  = ST_DIGITS;
                    end else if (w_isTerm) begin
                        w_errSet    = 1'b1;
                        w_nextState = ST_IDLE;
                    end else begin
                        w_nextState = ST_DISCARD;
                    end
                end
                ST_DIGITS: begin
                    if (w_isDigit) begin
                        if (w_count == 3'(MAX_DIGITS)) w_nextState = ST_DISCARD;
                        else                           w_digitEn   = 1'b1;
                    end else if (w_isTerm) begin
                        w_write     = (w_count != 3'd0);
                        w_errSet    = (w_count == 3'd0);
                        w_nextState = ST_IDLE;
                    end else begin
                        w_nextState = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (w_isTerm) begin
                        w_errSet    = 1'b1;
                        w_nextState = ST_IDLE;
                    end
                end
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nextState;
    end

    // '0' is 0x30, so the low three bits of a channel digit are the index itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch     <= '0;
            r_field  <= FLD_FREQ;
            r_update <= 1'b0;
            r_err    <= 1'b0;
            r_updCh  <= '0;
        end else begin
            r_update <= w_write;
            r_err    <= w_errSet;
            if (w_latchCh)    r_ch    <= rx_data[2:0];
            if (w_latchField) r_field <= to_field(rx_data);
            if (w_write)      r_updCh <= r_ch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_freq[k]  <= FREQ_W'(FREQ_RST);
                r_amp[k]   <= '1;
                r_phase[k] <= '0;
                r_wave[k]  <= '0;
            end
        end else if (w_write) begin
            for (int k = 0; k < NCH; k++) begin
                if (r_ch == 3'(k)) begin
                    case (r_field)
                        FLD_FREQ:  r_freq[k]  <= w_satValue[FREQ_W-1:0];
                        FLD_AMP:   r_amp[k]   <= w_satValue[AMP_W-1:0];
                        FLD_PHASE: r_phase[k] <= w_satValue[PHASE_W-1:0];
                        default:   r_wave[k]  <= w_satValue[WAVE_W-1:0];
                    endcase
                end
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_pack
        assign freq_o[k*FREQ_W +: FREQ_W]    = r_freq[k];
        assign amp_o[k*AMP_W +: AMP_W]       = r_amp[k];
        assign phase_o[k*PHASE_W +: PHASE_W] = r_phase[k];
        assign wave_o[k*WAVE_W +: WAVE_W]    = r_wave[k];
    end

    assign update = r_update;
    assign err    = r_err;
    assign upd_ch = r_updCh;

endmodule

// File: tb/tb_awg_cmd_parser.sv
// Self-checking bench for awg_cmd_parser: a line-level reference model is
// compared against the DUT every cycle, plus literal checks at key points.
module tb_awg_cmd_parser;

    localparam int NCH      = 2;
    localparam int FREQ_W   = 16;
    localparam int AMP_W    = 3;
    localparam int PHASE_W  = 8;
    localparam int WAVE_W   = 2;
    localparam int FREQ_RST = 1;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic [NCH*FREQ_W-1:0]  freq_o;
    logic [NCH*AMP_W-1:0]   amp_o;
    logic [NCH*PHASE_W-1:0] phase_o;
    logic [NCH*WAVE_W-1:0]  wave_o;
    logic                   update;
    logic [2:0]             upd_ch;
    logic                   err;

    int checkCount = 0;
    int passCount  = 0;
    int updSeen    = 0;
    int errSeen    = 0;
    int lastUpdCh  = 0;
    int updBase, errBase;

    // Reference model state: register contents and expected strobes.
    int freqM [NCH];
    int ampM  [NCH];
    int phaseM[NCH];
    int waveM [NCH];
    int expUpdate, expErr, expUpdCh;
    logic [7:0] lineBuf[$];

    awg_cmd_parser #(
        .NCH(NCH), .FREQ_W(FREQ_W), .AMP_W(AMP_W),
        .PHASE_W(PHASE_W), .WAVE_W(WAVE_W), .FREQ_RST(FREQ_RST)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .freq_o(freq_o), .amp_o(amp_o), .phase_o(phase_o), .wave_o(wave_o),
        .update(update), .upd_ch(upd_ch), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    function automatic void modelReset();
        for (int k = 0; k < NCH; k++) begin
            freqM[k]  = FREQ_RST;
            ampM[k]   = (1 << AMP_W) - 1;
            phaseM[k] = 0;
            waveM[k]  = 0;
        end
        expUpdate = 0;
        expErr    = 0;
        expUpdCh  = 0;
        lineBuf.delete();
    endfunction

    function automatic int sat(input int value, input int width);
        int maxv;
        maxv = (1 << width) - 1;
        return (value > maxv) ? maxv : value;
    endfunction

    // Judges a whole line at its terminator: write if well-formed, err otherwise.
    function automatic void modelLine();
        bit ok;
        int ch, nd, value;
        logic [7:0] f;
        ok = (lineBuf.size() >= 3) && (lineBuf.size() <= 7);
        value = 0;
        ch = 0;
        f = 8'h00;
        if (ok) begin
            ch = int'(lineBuf[0]) - 48;
            f  = lineBuf[1];
            if (ch < 0 || ch >= NCH) ok = 0;
            if (!(f == "F" || f == "A" || f == "P" || f == "W")) ok = 0;
            nd = lineBuf.size() - 2;
            for (int i = 0; i < nd; i++) begin
                if (lineBuf[i+2] < "0" || lineBuf[i+2] > "9") ok = 0;
                else value = value * 10 + (int'(lineBuf[i+2]) - 48);
            end
        end
        if (ok) begin
            case (f)
                "F": freqM[ch]  = sat(value, FREQ_W);
                "A": ampM[ch]   = sat(value, AMP_W);
                "P": phaseM[ch] = sat(value, PHASE_W);
                default: waveM[ch] = sat(value, WAVE_W);
            endcase
            expUpdate = 1;
            expUpdCh  = ch;
        end else begin
            expErr = 1;
        end
    endfunction

    function automatic void modelStep(input logic v, input logic [7:0] b);
        expUpdate = 0;
        expErr    = 0;
        if (v) begin
            if (b == CR || b == LF) begin
                if (lineBuf.size() != 0) modelLine();
                lineBuf.delete();
            end else if (lineBuf.size() < 16) begin
                lineBuf.push_back(b);
            end else begin
                lineBuf.push_back(8'h00);
            end
        end
    endfunction

    function automatic logic [NCH*FREQ_W-1:0] expFreq();
        logic [NCH*FREQ_W-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*FREQ_W +: FREQ_W] = FREQ_W'(freqM[k]);
        return r;
    endfunction

    function automatic logic [NCH*AMP_W-1:0] expAmp();
        logic [NCH*AMP_W-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*AMP_W +: AMP_W] = AMP_W'(ampM[k]);
        return r;
    endfunction

    function automatic logic [NCH*PHASE_W-1:0] expPhase();
        logic [NCH*PHASE_W-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*PHASE_W +: PHASE_W] = PHASE_W'(phaseM[k]);
        return r;
    endfunction

    function automatic logic [NCH*WAVE_W-1:0] expWave();
        logic [NCH*WAVE_W-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*WAVE_W +: WAVE_W] = WAVE_W'(waveM[k]);
        return r;
    endfunction

    // Per-cycle comparison against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        checkOutput("freq_o",  64'(freq_o),  64'(expFreq()));
        checkOutput("amp_o",   64'(amp_o),   64'(expAmp()));
        checkOutput("phase_o", 64'(phase_o), 64'(expPhase()));
        checkOutput("wave_o",  64'(wave_o),  64'(expWave()));
        checkOutput("update",  64'(update),  64'(expUpdate));
        checkOutput("err",     64'(err),     64'(expErr));
        checkOutput("upd_ch",  64'(upd_ch),  64'(expUpdCh));
        if (update) begin
            updSeen++;
            lastUpdCh = int'(upd_ch);
        end
        if (err) errSeen++;
    end

    // Called at posedge+1; drives one cycle and advances the model on its edge.
    task automatic applyStimulus(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        #1;
        modelStep(v, b);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        applyStimulus(1'b1, b);
        repeat (gap) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic sendStr(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) sendByte(s[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic applyReset(input int n);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        modelReset();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_freq",  64'(freq_o),  64'({16'd1, 16'd1}));
        checkOutput("rst_amp",   64'(amp_o),   64'({3'd7, 3'd7}));
        checkOutput("rst_phase", 64'(phase_o), 64'd0);
        checkOutput("rst_wave",  64'(wave_o),  64'd0);
        checkOutput("rst_update", 64'(update), 64'd0);
        checkOutput("rst_err",   64'(err),     64'd0);
        rst = 1'b0;
        idle(2);

        updBase = updSeen;
        sendStr("1F1000", 0); sendByte(LF, 0); idle(2);
        checkOutput("ch1_freq_1000", 64'(freq_o), 64'({16'd1000, 16'd1}));
        checkOutput("ch1_upd_count", 64'(updSeen - updBase), 64'd1);
        checkOutput("ch1_upd_ch",    64'(lastUpdCh), 64'd1);

        sendStr("0A9", 0); sendByte(CR, 0); idle(1);
        checkOutput("amp_sat", 64'(amp_o), 64'({3'd7, 3'd7}));
        sendStr("0P300", 0); sendByte(CR, 0); idle(1);
        checkOutput("phase_sat", 64'(phase_o), 64'({8'd0, 8'd255}));
        sendStr("0F99999", 0); sendByte(CR, 0); idle(1);
        checkOutput("freq_sat", 64'(freq_o), 64'({16'd1000, 16'd65535}));

        updBase = updSeen;
        errBase = errSeen;
        sendStr("5F10", 0);     sendByte(LF, 0);
        sendStr("0X1", 0);      sendByte(LF, 0);
        sendStr("0F", 0);       sendByte(LF, 0);
        sendStr("0F123456", 0); sendByte(LF, 0);
        idle(2);
        checkOutput("bad_err_count", 64'(errSeen - errBase), 64'd4);
        checkOutput("bad_upd_count", 64'(updSeen - updBase), 64'd0);
        checkOutput("bad_freq_kept", 64'(freq_o), 64'({16'd1000, 16'd65535}));
        checkOutput("bad_phase_kept", 64'(phase_o), 64'({8'd0, 8'd255}));

        updBase = updSeen;
        errBase = errSeen;
        sendStr("0W2", 3); sendByte(CR, 3); sendByte(LF, 3);
        checkOutput("wave_ch0", 64'(wave_o), 64'({2'd0, 2'd2}));
        checkOutput("wave_upd_count", 64'(updSeen - updBase), 64'd1);
        checkOutput("wave_err_count", 64'(errSeen - errBase), 64'd0);

        sendStr("1A2", 0); sendByte(LF, 0); idle(1);
        checkOutput("amp_ch1", 64'(amp_o), 64'({3'd2, 3'd7}));

        sendStr("1F12", 0);
        applyReset(1);
        updBase = updSeen;
        errBase = errSeen;
        sendStr("34", 0); sendByte(LF, 0);
        sendStr("1F7", 0); sendByte(LF, 0);
        idle(2);
        checkOutput("abort_err_count", 64'(errSeen - errBase), 64'd1);
        checkOutput("abort_upd_count", 64'(updSeen - updBase), 64'd1);
        checkOutput("abort_freq", 64'(freq_o), 64'({16'd7, 16'd1}));
        checkOutput("abort_amp",  64'(amp_o),  64'({3'd7, 3'd7}));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/awg_cmd_parser.md
AWG_CMD_PARSER -- requirements
Module: awg_cmd_parser

Interface
REQ-001 Parameter NCH, default 2, number of AWG channels (1..8).
REQ-002 Parameter FREQ_W, default 16, frequency-word width per channel.
REQ-003 Parameter AMP_W, default 3, amplitude-code width per channel.
REQ-004 Parameter PHASE_W, default 8, phase-offset width per channel.
REQ-005 Parameter WAVE_W, default 2, waveform-select width per channel.
REQ-006 Parameter FREQ_RST, default 1, frequency reset value for every channel.
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 rx_data  in  8  ASCII byte from UART receiver.
REQ-010 rx_valid  in  1  one-cycle strobe; rx_data valid when high.
REQ-011 freq_o  out  NCH*FREQ_W  per-channel frequency words, channel k at bits [k*FREQ_W +: FREQ_W].
REQ-012 amp_o  out  NCH*AMP_W  per-channel amplitude codes, same packing.
REQ-013 phase_o  out  NCH*PHASE_W  per-channel phase offsets, same packing.
REQ-014 wave_o  out  NCH*WAVE_W  per-channel waveform selects, same packing.
REQ-015 update  out  1  one-cycle pulse: a channel field was written.
REQ-016 upd_ch  out  3  channel index of the last write; valid with update, held otherwise.
REQ-017 err  out  1  one-cycle pulse: malformed command discarded.

Function
REQ-018 Command grammar: <ch><field><digits><term>; ch '0'..('0'+NCH-1); field 'F','A','P','W' (uppercase only); digits '0'..'9', 1..5 of them; term CR (0x0D) or LF (0x0A).
REQ-019 Bytes with rx_valid low are ignored; one byte consumed per rx_valid cycle, back-to-back strobes supported.
REQ-020 FSM states: IDLE, FIELD, DIGITS, DISCARD.
REQ-021 IDLE: valid ch -> latch channel, go FIELD; term -> stay IDLE, no err (blank line); other byte -> DISCARD.
REQ-022 FIELD: valid field letter -> latch field, clear accumulator, go DIGITS; other byte -> DISCARD (term -> IDLE with err).
REQ-023 DIGITS: digit -> acc = acc*10 + digit (17-bit acc), digit count +1; sixth digit -> DISCARD; term with count>=1 -> write, go IDLE; term with count=0 -> err, go IDLE; other byte -> DISCARD.
REQ-024 DISCARD: swallow bytes until term, then pulse err and go IDLE.
REQ-025 Write: selected field of selected channel <= min(acc, 2^width-1) (saturate, never wrap); other fields/channels unchanged.
REQ-026 Latency: field register, update and upd_ch all change on the same edge that consumes the term byte; update high exactly one cycle.
REQ-027 err high exactly one cycle, on the edge consuming the term that ends a malformed command; update and err never both high.
REQ-028 CR immediately followed by LF: second term seen in IDLE, ignored.

Reset
REQ-029 While rst high: state IDLE, acc 0, count 0, update 0, err 0, upd_ch 0.
REQ-030 Reset values: every freq FREQ_RST, amp 2^AMP_W-1, phase 0, wave 0.
REQ-031 rst asserted mid-command aborts it with no write and no err; first byte after release parsed from IDLE.

Structure
REQ-032 Shared package awg_pkg holds ASCII constants (CR, LF, '0', 'F','A','P','W'), FSM state encoding and field-select codes.
REQ-033 One sub-module, awg_dec_acc: decimal accumulate/count/saturate datapath (clear, digit-in, sat width select); FSM and channel register file stay in top.

Verification
REQ-034 Reset, NCH=2: freq_o=={16'd1,16'd1}, amp_o=={3'd7,3'd7}, phase_o=0, wave_o=0, update=0, err=0.
REQ-035 Send "1F1000\n" back-to-back -> channel-1 freq 1000, channel 0 unchanged, update one cycle with upd_ch=1 on the LF edge.
REQ-036 Send "0A9\r" -> amp ch0 = 7 (saturated); "0P300\r" -> phase ch0 = 255; "0F99999\r" -> freq ch0 = 65535.
REQ-037 Send "5F10\n" (NCH=2), "0X1\n", "0F\n", "0F123456\n" -> four err pulses, no update, all outputs unchanged.
REQ-038 Send "0W2\r\n" with 3 idle cycles between bytes -> wave ch0 = 2, exactly one update, no err from trailing LF.
REQ-039 Send "1F12", assert rst 1 cycle, send "34\n" then "1F7\n" -> first yields err only, second sets freq ch1 = 7, no write of 1234.
